// File: rtl/ps2_rx_fifo_pkg.sv
// Shared PS/2 receive definitions: prefix bytes, frame geometry and the FIFO entry layout.
`timescale 1ns/1ps
package ps2_pkg;

    localparam logic [7:0] PS2_PREFIX_BREAK = 8'hF0;
    localparam logic [7:0] PS2_PREFIX_EXT   = 8'hE0;
    localparam int         PS2_FRAME_BITS   = 11;
    localparam int         PS2_ENTRY_W      = 10;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_entry_t;

    // Data byte plus parity bit must hold an odd number of ones.
    function automatic logic ps2_parity_ok(input logic [8:0] data_par);
        return ^data_par;
    endfunction

endpackage

// File: rtl/ps2_rx_fifo_if.sv
// Read-side bundle of the PS/2 receiver: pop/clear requests in, head entry, level and error flags out.
`timescale 1ns/1ps
interface ps2_rx_fifo_if #(
    parameter int DEPTH = 8
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             rd_en;
    logic             clr_err;
    logic             valid;
    logic [7:0]       code;
    logic             brk;
    logic             ext;
    logic [LVL_W-1:0] level;
    logic             overflow;
    logic             parity_err;
    logic             frame_err;

    modport master (
        output rd_en, clr_err,
        input  valid, code, brk, ext, level, overflow, parity_err, frame_err
    );

    modport slave (
        input  rd_en, clr_err,
        output valid, code, brk, ext, level, overflow, parity_err, frame_err
    );

endinterface

// File: rtl/ps2_rx_fifo_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with explicit occupancy tracking.
`timescale 1ns/1ps
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_LVL = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   level_q, level_d;
    logic             do_push, do_pop;

    always_comb begin
        empty    = (level_q == '0);
        full     = (level_q == FULL_LVL);
        do_pop   = pop & ~empty;
        // A full FIFO still accepts a write when the head leaves in the same cycle.
        do_push  = push & (~full | do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        rdata = empty ? '0 : mem_q[rd_ptr_q];
        level = level_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchroniser, 11-bit deframer with watchdog, F0/E0 prefix merging,
// sticky error flags and a FWFT FIFO toward the scan-code consumer.
`timescale 1ns/1ps
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 16384,
    parameter int MERGE_PREFIX   = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ps2_clk,
    input  logic                ps2_data,
    ps2_rx_fifo_if.slave        bus
);
    localparam int             LVL_W    = $clog2(DEPTH) + 1;
    localparam int             WD_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);
    localparam logic [3:0]     LAST_BIT = 4'(PS2_FRAME_BITS - 1);

    logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
    logic                   clk_prev_q;
    logic                   clk_s, data_s, sample;

    logic [3:0]      cnt_q, cnt_d;
    logic [9:0]      bits_q, bits_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            pend_brk_q, pend_brk_d;
    logic            pend_ext_q, pend_ext_d;
    logic            ovf_q, ovf_d, par_q, par_d, frm_q, frm_d;

    logic            push, par_evt, frm_evt, drop;
    ps2_entry_t      wr_entry, head;
    logic [7:0]      rx_byte;

    logic [PS2_ENTRY_W-1:0] fifo_rdata;
    logic                   fifo_full, fifo_empty;
    logic [LVL_W-1:0]       fifo_level;

    // Both lines share the same stage index so data and edge stay aligned.
    assign clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign data_s = data_sync_q[SYNC_STAGES-1];
    assign sample = clk_prev_q & ~clk_s;
    assign rx_byte = bits_q[8:1];

    always_comb begin
        cnt_d      = cnt_q;
        bits_d     = bits_q;
        wd_d       = wd_q;
        pend_brk_d = pend_brk_q;
        pend_ext_d = pend_ext_q;
        push       = 1'b0;
        par_evt    = 1'b0;
        frm_evt    = 1'b0;
        wr_entry   = '{ext: pend_ext_q, brk: pend_brk_q, code: rx_byte};
        if (sample) begin
            wd_d = '0;
            if (cnt_q == LAST_BIT) begin
                cnt_d   = '0;
                par_evt = ~ps2_parity_ok(bits_q[9:1]);
                frm_evt = bits_q[0] | ~data_s;
                if (par_evt || frm_evt) begin
                    pend_brk_d = 1'b0;
                    pend_ext_d = 1'b0;
                end else if (MERGE_PREFIX != 0 && rx_byte == PS2_PREFIX_BREAK) begin
                    pend_brk_d = 1'b1;
                end else if (MERGE_PREFIX != 0 && rx_byte == PS2_PREFIX_EXT) begin
                    pend_ext_d = 1'b1;
                end else begin
                    push       = 1'b1;
                    pend_brk_d = 1'b0;
                    pend_ext_d = 1'b0;
                end
            end else begin
                bits_d[cnt_q] = data_s;
                cnt_d         = cnt_q + 1'b1;
            end
        end else if (cnt_q != '0) begin
            // A stalled partial frame is abandoned so the next start bit resynchronises.
            wd_d = wd_q + 1'b1;
            if (wd_d == WD_LIMIT) begin
                wd_d       = '0;
                cnt_d      = '0;
                frm_evt    = 1'b1;
                pend_brk_d = 1'b0;
                pend_ext_d = 1'b0;
            end
        end
    end

    always_comb begin
        drop  = push & fifo_full & ~(bus.rd_en & ~fifo_empty);
        ovf_d = (ovf_q & ~bus.clr_err) | drop;
        par_d = (par_q & ~bus.clr_err) | par_evt;
        frm_d = (frm_q & ~bus.clr_err) | frm_evt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
            cnt_q       <= '0;
            wd_q        <= '0;
            pend_brk_q  <= 1'b0;
            pend_ext_q  <= 1'b0;
            ovf_q       <= 1'b0;
            par_q       <= 1'b0;
            frm_q       <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
            clk_prev_q  <= clk_s;
            cnt_q       <= cnt_d;
            wd_q        <= wd_d;
            pend_brk_q  <= pend_brk_d;
            pend_ext_q  <= pend_ext_d;
            ovf_q       <= ovf_d;
            par_q       <= par_d;
            frm_q       <= frm_d;
        end
    end

    always_ff @(posedge clk) begin
        bits_q <= bits_d;
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PS2_ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (bus.rd_en),
        .wdata (wr_entry),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign head           = ps2_entry_t'(fifo_rdata);
    assign bus.valid      = ~fifo_empty;
    assign bus.code       = head.code;
    assign bus.brk        = head.brk;
    assign bus.ext        = head.ext;
    assign bus.level      = fifo_level;
    assign bus.overflow   = ovf_q;
    assign bus.parity_err = par_q;
    assign bus.frame_err  = frm_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench: one raw-mode and one merge-mode receiver share the PS/2 lines.
`timescale 1ns/1ps
module tb_ps2_rx_fifo;
    localparam int HALF    = 8;
    localparam int TIMEOUT = 200;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;
    int   tests_run = 0;
    int   tests_failed = 0;

    ps2_rx_fifo_if #(.DEPTH(8)) if0 ();
    ps2_rx_fifo_if #(.DEPTH(8)) if1 ();

    ps2_rx_fifo #(.DEPTH(8), .SYNC_STAGES(2), .TIMEOUT_CYCLES(TIMEOUT), .MERGE_PREFIX(0)) dut0 (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .bus(if0.slave));
    ps2_rx_fifo #(.DEPTH(8), .SYNC_STAGES(2), .TIMEOUT_CYCLES(TIMEOUT), .MERGE_PREFIX(1)) dut1 (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .bus(if1.slave));

    always #5 clk = ~clk;

    task automatic ps2_bit(input logic b);
        @(negedge clk) ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_head(input logic [7:0] d, input logic par_flip);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit((~^d) ^ par_flip);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop);
        send_head(d, par_flip);
        ps2_bit(stop);
        repeat (6) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
        if0.rd_en = 1'b0; if0.clr_err = 1'b0; if1.rd_en = 1'b0; if1.clr_err = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic pop1();
        @(negedge clk) if1.rd_en = 1'b1;
        @(negedge clk) if1.rd_en = 1'b0;
    endtask

    task automatic clear_errs();
        @(negedge clk) begin if0.clr_err = 1'b1; if1.clr_err = 1'b1; end
        @(negedge clk) begin if0.clr_err = 1'b0; if1.clr_err = 1'b0; end
    endtask

    task automatic test_reset();
        logic [15:0] st0, st1;
        do_reset();
        st0 = {if0.valid, if0.code, if0.brk, if0.ext, if0.level, if0.overflow, if0.parity_err, if0.frame_err};
        st1 = {if1.valid, if1.code, if1.brk, if1.ext, if1.level, if1.overflow, if1.parity_err, if1.frame_err};
        tests_run++;
        if (st0 !== 16'h0) begin tests_failed++; $display("FAIL reset_raw: got %h want 0000", st0); end
        tests_run++;
        if (st1 !== 16'h0) begin tests_failed++; $display("FAIL reset_merge: got %h want 0000", st1); end
    endtask

    task automatic test_single();
        do_reset();
        send_head(8'h1C, 1'b0);
        @(negedge clk) ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        tests_run++;
        if (if0.valid !== 1'b0) begin tests_failed++; $display("FAIL single_early_valid: got %b want 0", if0.valid); end
        @(posedge clk); #1;
        tests_run++;
        if ({if0.valid, if0.code, if0.brk, if0.ext, if0.level} !== {1'b1, 8'h1C, 1'b0, 1'b0, 4'd1}) begin
            tests_failed++;
            $display("FAIL single_head: got v=%b code=%h brk=%b ext=%b lvl=%0d want v=1 code=1c brk=0 ext=0 lvl=1",
                     if0.valid, if0.code, if0.brk, if0.ext, if0.level);
        end
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
        @(negedge clk) if0.rd_en = 1'b1;
        @(negedge clk) if0.rd_en = 1'b0;
        tests_run++;
        if ({if0.valid, if0.level} !== 5'd0) begin
            tests_failed++; $display("FAIL single_pop: got v=%b lvl=%0d want v=0 lvl=0", if0.valid, if0.level);
        end
        @(negedge clk) if0.rd_en = 1'b1;
        repeat (3) @(negedge clk);
        if0.rd_en = 1'b0;
        tests_run++;
        if ({if0.valid, if0.level} !== 5'd0) begin
            tests_failed++; $display("FAIL empty_pop: got v=%b lvl=%0d want v=0 lvl=0", if0.valid, if0.level);
        end
    endtask

    task automatic test_merge();
        do_reset();
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b1);
        tests_run++;
        if ({if1.level, if1.code, if1.brk, if1.ext} !== {4'd1, 8'h1C, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL merge_break: got lvl=%0d code=%h brk=%b ext=%b want lvl=1 code=1c brk=1 ext=0",
                     if1.level, if1.code, if1.brk, if1.ext);
        end
        tests_run++;
        if ({if0.level, if0.code, if0.brk} !== {4'd2, 8'hF0, 1'b0}) begin
            tests_failed++;
            $display("FAIL raw_prefix: got lvl=%0d code=%h brk=%b want lvl=2 code=f0 brk=0", if0.level, if0.code, if0.brk);
        end
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h75, 1'b0, 1'b1);
        tests_run++;
        if (if1.level !== 4'd2) begin tests_failed++; $display("FAIL merge_level: got %0d want 2", if1.level); end
        pop1();
        tests_run++;
        if ({if1.code, if1.brk, if1.ext} !== {8'h75, 1'b1, 1'b1}) begin
            tests_failed++;
            $display("FAIL merge_ext_break: got code=%h brk=%b ext=%b want code=75 brk=1 ext=1", if1.code, if1.brk, if1.ext);
        end
    endtask

    task automatic test_errors();
        do_reset();
        send_frame(8'h1B, 1'b1, 1'b1);
        tests_run++;
        if ({if1.valid, if1.parity_err, if1.frame_err} !== 3'b010) begin
            tests_failed++;
            $display("FAIL parity_err: got v=%b par=%b frm=%b want v=0 par=1 frm=0", if1.valid, if1.parity_err, if1.frame_err);
        end
        clear_errs();
        tests_run++;
        if (if1.parity_err !== 1'b0) begin tests_failed++; $display("FAIL parity_clr: got %b want 0", if1.parity_err); end
        send_frame(8'h1B, 1'b0, 1'b0);
        tests_run++;
        if ({if1.valid, if1.parity_err, if1.frame_err} !== 3'b001) begin
            tests_failed++;
            $display("FAIL stop_err: got v=%b par=%b frm=%b want v=0 par=0 frm=1", if1.valid, if1.parity_err, if1.frame_err);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp;
        do_reset();
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b1);
        tests_run++;
        if ({if1.level, if1.overflow} !== {4'd8, 1'b1}) begin
            tests_failed++; $display("FAIL overflow: got lvl=%0d ovf=%b want lvl=8 ovf=1", if1.level, if1.overflow);
        end
        for (int i = 1; i <= 8; i++) begin
            exp = 8'(i);
            tests_run++;
            if ({if1.valid, if1.code} !== {1'b1, exp}) begin
                tests_failed++; $display("FAIL drain_order: got v=%b code=%h want v=1 code=%h", if1.valid, if1.code, exp);
            end
            pop1();
        end
        tests_run++;
        if (if1.valid !== 1'b0) begin tests_failed++; $display("FAIL drain_empty: got %b want 0", if1.valid); end
    endtask

    task automatic test_full_pop();
        do_reset();
        for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b0, 1'b1);
        send_head(8'h09, 1'b0);
        @(negedge clk) ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (2) @(negedge clk);
        if1.rd_en = 1'b1;
        @(negedge clk) if1.rd_en = 1'b0;
        repeat (HALF - 3) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (4) @(negedge clk);
        tests_run++;
        if ({if1.level, if1.overflow, if1.code} !== {4'd8, 1'b0, 8'h02}) begin
            tests_failed++;
            $display("FAIL full_push_pop: got lvl=%0d ovf=%b code=%h want lvl=8 ovf=0 code=02", if1.level, if1.overflow, if1.code);
        end
        repeat (7) pop1();
        tests_run++;
        if ({if1.level, if1.code} !== {4'd1, 8'h09}) begin
            tests_failed++; $display("FAIL full_tail: got lvl=%0d code=%h want lvl=1 code=09", if1.level, if1.code);
        end
    endtask

    task automatic test_robust();
        logic [15:0] st;
        do_reset();
        for (int i = 0; i < 5; i++) ps2_bit(i == 0 ? 1'b0 : 1'b1);
        repeat (TIMEOUT + 20) @(negedge clk);
        tests_run++;
        if ({if1.frame_err, if1.level} !== {1'b1, 4'd0}) begin
            tests_failed++; $display("FAIL watchdog: got frm=%b lvl=%0d want frm=1 lvl=0", if1.frame_err, if1.level);
        end
        clear_errs();
        send_frame(8'h1C, 1'b0, 1'b1);
        tests_run++;
        if ({if1.valid, if1.code, if1.frame_err, if1.parity_err} !== {1'b1, 8'h1C, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL after_timeout: got v=%b code=%h frm=%b par=%b want v=1 code=1c frm=0 par=0",
                     if1.valid, if1.code, if1.frame_err, if1.parity_err);
        end
        for (int i = 0; i < 5; i++) ps2_bit(i == 0 ? 1'b0 : 1'b1);
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        st = {if1.valid, if1.code, if1.brk, if1.ext, if1.level, if1.overflow, if1.parity_err, if1.frame_err};
        tests_run++;
        if (st !== 16'h0) begin tests_failed++; $display("FAIL mid_reset: got %h want 0000", st); end
        reset = 1'b0;
        send_frame(8'h2A, 1'b0, 1'b1);
        tests_run++;
        if ({if1.valid, if1.code, if1.level, if1.frame_err} !== {1'b1, 8'h2A, 4'd1, 1'b0}) begin
            tests_failed++;
            $display("FAIL after_reset: got v=%b code=%h lvl=%0d frm=%b want v=1 code=2a lvl=1 frm=0",
                     if1.valid, if1.code, if1.level, if1.frame_err);
        end
    endtask

    initial begin
        if0.rd_en = 1'b0; if0.clr_err = 1'b0;
        if1.rd_en = 1'b0; if1.clr_err = 1'b0;
        test_reset();
        test_single();
        test_merge();
        test_errors();
        test_overflow();
        test_full_pop();
        test_robust();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
Parametrised PS/2 device-to-host receiver with a configurable-depth FIFO and a valid/pop read handshake.
- Synchronises ps2_clk/ps2_data and deframes 11-bit frames (start, 8 data LSB-first, odd parity, stop).
- Adds a frame watchdog, sticky error flags and optional merging of F0/E0 prefixes into tagged scan codes.
- Feeds the keyboard/scan-code consumer in the NPC peripheral path.

Parameters:
DEPTH, 8, FIFO entries; power of 2, ≥2
SYNC_STAGES, 2, synchroniser flops on ps2_clk and ps2_data; ≥2
TIMEOUT_CYCLES, 16384, clk cycles with no ps2_clk falling edge before a partial frame is aborted
MERGE_PREFIX, 1, 1: F0/E0 absorbed into brk/ext tags; 0: every byte pushed raw, tags 0

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
ps2_clk  in  1  asynchronous PS/2 clock
ps2_data  in  1  asynchronous PS/2 data
rd_en  in  1  pop request; honoured only when valid=1
clr_err  in  1  clears sticky error flags
valid  out  1  FIFO non-empty; head word on code/brk/ext
code  out  8  head scan code
brk  out  1  head entry was preceded by F0
ext  out  1  head entry was preceded by E0
level  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH
overflow  out  1  sticky: a good frame was dropped because the FIFO was full
parity_err  out  1  sticky: parity check failed
frame_err  out  1  sticky: bad start/stop bit or watchdog abort

Behaviour:
- Reset (sync, active-high, wins over every other event):
  - Pointers, level, bit count, watchdog, prefix flags and sticky errors go to 0.
  - valid=0, code/brk/ext=0, synchroniser flops set to 1 (idle bus).
  - Reset mid-frame discards the partial frame.
- Synchronisation:
  - ps2_clk and ps2_data each pass through SYNC_STAGES flops.
  - Falling edge ("sample") = previous synced clk 1 and current synced clk 0. It is a 1-cycle pulse.
  - Data is sampled from the synced ps2_data of the same stage, so both lines have equal latency.
- Deframer:
  - Bit counter runs 0..10. Each sample stores bit[count] and then increments the counter.
  - On the sample at count=10 the frame is checked and the counter returns to 0.
  - Good frame: bit0=0, stop=1, ^bits[9:1]=1 (odd parity).
  - Parity fail sets parity_err. Bad start or stop bit sets frame_err. A failing frame is discarded and clears the prefix flags.
- Watchdog:
  - Counts clk cycles while count≠0 and resets to 0 on every sample.
  - When it reaches TIMEOUT_CYCLES: count←0, frame_err←1, prefix flags cleared.
  - Never fires while idle (count=0).
- Prefix merge (MERGE_PREFIX=1):
  - Good byte F0 sets pend_brk, E0 sets pend_ext. Neither byte is pushed.
  - Any other good byte is pushed with {pend_ext,pend_brk}, then both flags clear.
  - E1 and other bytes are treated as ordinary codes.
  - If the push of a tagged byte is dropped for overflow, the flags still clear.
- FIFO:
  - Write occurs in the check cycle N; valid=1 and new level are visible in cycle N+1.
  - Pop when rd_en=1 and valid=1; the next head is visible the following cycle (first-word-fall-through).
  - rd_en while empty: ignored, no pointer movement.
  - Push is accepted when level<DEPTH, or when level=DEPTH and a pop occurs in the same cycle.
  - Otherwise the byte is dropped, overflow←1 and the FIFO contents are unchanged.
  - Simultaneous push and pop: level is unchanged.
  - Pointers are $clog2(DEPTH) bits and wrap naturally. level is tracked explicitly.
- Errors:
  - Flags stay set until clr_err=1 or reset.
  - If clr_err coincides with a new error event, the flag remains 1 (set wins).

Decomposition:
- Shared package ps2_pkg: PS2_PREFIX_BREAK=8'hF0, PS2_PREFIX_EXT=8'hE0, PS2_FRAME_BITS=11, entry struct {ext, brk, code[7:0]}.
- One sub-module: sync_fifo (DEPTH, WIDTH=10; push/pop/full/empty/level), reusable elsewhere.
- Deframer, watchdog and prefix logic stay in ps2_rx_fifo.

Test Plan:
- Send 0x1C with MERGE_PREFIX=0 → valid=1 one cycle after the stop sample; code=1C, brk=0, ext=0, level=1. After pop: valid=0, level=0.
- Send F0 then 1C with MERGE_PREFIX=1 → exactly one entry: code=1C, brk=1, ext=0. Then E0, F0, 75 → code=75, brk=1, ext=1, level=2.
- Send 0x1B with the parity bit inverted → no push, parity_err=1, then clr_err → 0. A bad stop bit gives frame_err=1.
- DEPTH=8: send 9 codes 01..09 with no pops → level=8, overflow=1. Pops return 01..08 in order, then valid=0.
- Full FIFO: a stop sample coincides with rd_en → push accepted, level stays 8, overflow unchanged.
- Robustness: send 5 bits then hold idle for TIMEOUT_CYCLES → frame_err=1, count reset, and the following 0x1C is received correctly. Assert reset mid-frame → all outputs 0 and the next frame is received correctly.
